main_memory: RTL and testbench

Behavioural main-memory responder for the cache-to-memory interface in the `cc` lab. It accepts one line-sized read or write request at a time from `cache` and waits a fixed access latency. For a read it returns the line as a burst of data beats; for a write it returns a single acknowledge beat. It is instantiated in `board` next to `core` and `cache` and closes the memory side of the hierarchy.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/cache_mem_if.sv | 27 ++
 rtl/mem_array.sv | 22 ++
 rtl/main_memory.sv | 151 +++++++++++++++
 tb/tb_main_memory.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory path: FSM states, default
// geometry, and the address-slicing helpers used by cache and memory alike.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, ACK} mem_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 4;

    // Byte-offset bits within one line.
    function automatic int off_bits(input int data_w, input int beats);
        return $clog2(beats * data_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/cache_mem_if.sv
// Cache-to-memory bundle: one line-sized request channel and a beat-wide
// response channel, both valid/ready.
interface cache_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W*BEATS-1:0]   req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_last;

    modport cache (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_last
    );

    modport memory (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_last
    );
endinterface

// File: rtl/mem_array.sv
// Line storage: synchronous write port, combinational read port.
// Contents are deliberately not reset so committed lines survive rst.
module mem_array #(
    parameter int LINE_W = 128,
    parameter int DEPTH  = 256,
    parameter int IW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     wr_idx,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IW-1:0]     rd_idx,
    output logic [LINE_W-1:0] rd_line
);
    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wdata;
    end

    assign rd_line = mem[rd_idx];
endmodule

// File: rtl/main_memory.sv
// Behavioural main memory: one outstanding line request, fixed access
// latency, read data returned as a beat burst, writes acknowledged once.
module main_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BEATS   = DEF_BEATS,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input logic         clk,
    input logic         rst,
    cache_mem_if.memory bus
);
    localparam int OFF    = off_bits(DATA_W, BEATS);
    localparam int IW     = idx_bits(DEPTH);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int BW     = $clog2(BEATS);
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     beat, beat_n;
    logic              we_q, we_n;
    logic [IW-1:0]     idx_q, idx_n;
    logic [LINE_W-1:0] line_q, line_n;
    logic              req_ready_q, req_ready_n;
    logic              resp_valid_q, resp_valid_n;
    logic [DATA_W-1:0] resp_data_q, resp_data_n;
    logic              resp_last_q, resp_last_n;

    logic              accept;
    logic [IW-1:0]     addr_idx;
    logic [LINE_W-1:0] rd_line;
    logic              unused_addr;

    assign addr_idx    = bus.req_addr[OFF +: IW];
    assign accept      = (state == IDLE) && req_ready_q && bus.req_valid;
    // Offset and tag bits are ignored on purpose: addresses alias.
    assign unused_addr = ^bus.req_addr;

    mem_array #(.LINE_W(LINE_W), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk    (clk),
        .we     (accept && bus.req_we),
        .wr_idx (addr_idx),
        .wdata  (bus.req_wdata),
        .rd_idx (idx_q),
        .rd_line(rd_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            beat         <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            line_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            beat         <= beat_n;
            we_q         <= we_n;
            idx_q        <= idx_n;
            line_q       <= line_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_data_q  <= resp_data_n;
            resp_last_q  <= resp_last_n;
        end
    end

    // Outputs are registered, so each branch sets them for the state being entered.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        beat_n       = beat;
        we_n         = we_q;
        idx_n        = idx_q;
        line_n       = line_q;
        req_ready_n  = req_ready_q;
        resp_valid_n = resp_valid_q;
        resp_data_n  = resp_data_q;
        resp_last_n  = resp_last_q;
        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (accept) begin
                    we_n        = bus.req_we;
                    idx_n       = addr_idx;
                    cnt_n       = CW'(LATENCY - 1);
                    req_ready_n = 1'b0;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    resp_valid_n = 1'b1;
                    if (we_q) begin
                        resp_data_n = '0;
                        resp_last_n = 1'b1;
                        state_n     = ACK;
                    end else begin
                        line_n      = rd_line;
                        resp_data_n = rd_line[DATA_W-1:0];
                        resp_last_n = 1'b0;
                        beat_n      = '0;
                        state_n     = BURST;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            BURST: begin
                if (bus.resp_ready) begin
                    if (beat == BW'(BEATS - 1)) begin
                        beat_n       = '0;
                        resp_valid_n = 1'b0;
                        resp_data_n  = '0;
                        resp_last_n  = 1'b0;
                        req_ready_n  = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        beat_n      = beat + 1'b1;
                        resp_data_n = line_q[beat_n*DATA_W +: DATA_W];
                        resp_last_n = (beat_n == BW'(BEATS - 1));
                    end
                end
            end
            ACK: begin
                if (bus.resp_ready) begin
                    resp_valid_n = 1'b0;
                    resp_last_n  = 1'b0;
                    req_ready_n  = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_last  = resp_last_q;
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a LATENCY=4 and a LATENCY=1 instance
// share clock and reset; drivers push expected beats, a monitor pops them.
module tb_main_memory;
    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    localparam logic [127:0] LA = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LB = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] LC = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q4[$];
    exp_t        q1[$];

    logic [1:0]   req_valid_t = '0;
    logic [1:0]   req_we_t = '0;
    logic [1:0]   resp_ready_t = 2'b11;
    logic [31:0]  req_addr_t [2];
    logic [127:0] req_wdata_t [2];
    logic [1:0]   req_ready_o, resp_valid_o, resp_last_o;
    logic [31:0]  resp_data_o [2];

    cache_mem_if #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) b4 ();
    cache_mem_if #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) b1 ();

    main_memory #(.ADDR_W(32), .DATA_W(32), .BEATS(4), .DEPTH(256), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4)
    );
    main_memory #(.ADDR_W(32), .DATA_W(32), .BEATS(4), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    assign b4.req_valid  = req_valid_t[0];
    assign b4.req_we     = req_we_t[0];
    assign b4.req_addr   = req_addr_t[0];
    assign b4.req_wdata  = req_wdata_t[0];
    assign b4.resp_ready = resp_ready_t[0];
    assign b1.req_valid  = req_valid_t[1];
    assign b1.req_we     = req_we_t[1];
    assign b1.req_addr   = req_addr_t[1];
    assign b1.req_wdata  = req_wdata_t[1];
    assign b1.resp_ready = resp_ready_t[1];

    assign req_ready_o    = {b1.req_ready, b4.req_ready};
    assign resp_valid_o   = {b1.resp_valid, b4.resp_valid};
    assign resp_last_o    = {b1.resp_last, b4.resp_last};
    assign resp_data_o[0] = b4.resp_data;
    assign resp_data_o[1] = b1.resp_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsz(input int s);
        return (s == 0) ? q4.size() : q1.size();
    endfunction

    task automatic push(input int s, input exp_t e);
        if (s == 0) q4.push_back(e);
        else q1.push_back(e);
    endtask

    // Front entry is compared on every valid cycle, so held beats must stay stable.
    task automatic observe(input int s, input logic v, input logic rdy,
                           input logic [31:0] d, input logic l);
        exp_t e;
        if (!v) return;
        if (qsz(s) == 0) begin
            chk($sformatf("spurious_beat_m%0d", s), 64'(v), 64'(0));
            return;
        end
        e = (s == 0) ? q4[0] : q1[0];
        chk($sformatf("resp_data_m%0d", s), 64'(d), 64'(e.data));
        chk($sformatf("resp_last_m%0d", s), 64'(l), 64'(e.last));
        if (rdy) begin
            if (e.cyc >= 0) chk($sformatf("beat_cycle_m%0d", s), 64'(cyc), 64'(e.cyc));
            if (s == 0) void'(q4.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            observe(0, resp_valid_o[0], resp_ready_t[0], resp_data_o[0], resp_last_o[0]);
            observe(1, resp_valid_o[1], resp_ready_t[1], resp_data_o[1], resp_last_o[1]);
        end
    end

    // Issue one request and push its expected beats; tm=0 times only the first beat.
    task automatic send(input int s, input logic we, input logic [31:0] addr,
                        input logic [127:0] line, input bit hold, input bit tm,
                        output int acc);
        int   n;
        int   lat;
        exp_t e;
        lat = (s == 0) ? 4 : 1;
        req_we_t[s]    = we;
        req_addr_t[s]  = addr;
        req_wdata_t[s] = we ? line : '0;
        req_valid_t[s] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_o[s] && n < 60);
        if (!req_ready_o[s]) begin
            chk($sformatf("accept_timeout_m%0d", s), 64'(req_ready_o[s]), 64'(1));
            req_valid_t[s] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) req_valid_t[s] = 1'b0;
        if (we) begin
            e.data = '0;
            e.last = 1'b1;
            e.cyc  = acc + lat;
            push(s, e);
        end else begin
            for (int j = 0; j < 4; j++) begin
                e.data = line[j*32 +: 32];
                e.last = (j == 3);
                e.cyc  = (tm || j == 0) ? acc + lat + j : -1;
                push(s, e);
            end
        end
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (qsz(s) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_m%0d", s), 64'(qsz(s)), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a, a0, a1, a2;
        req_addr_t[0] = '0; req_addr_t[1] = '0;
        req_wdata_t[0] = '0; req_wdata_t[1] = '0;

        // Reset: outputs low throughout, req_ready one edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o[0]), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid_o[0]), 64'(0));
        chk("rst_resp_data", 64'(resp_data_o[0]), 64'(0));
        chk("rst_resp_last", 64'(resp_last_o[0]), 64'(0));
        chk("rst_req_ready_m1", 64'(req_ready_o[1]), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", 64'(req_ready_o[0]), 64'(0));
        @(posedge clk);
        #1;
        chk("ready_after_edge", 64'(req_ready_o[0]), 64'(1));

        // Write then read, resp_ready high
        send(0, 1'b1, 32'h40, LA, 0, 1, a); drain(0);
        send(0, 1'b0, 32'h40, LA, 0, 1, a); drain(0);

        // Backpressure: stall 5 cycles on beat 1
        send(0, 1'b0, 32'h40, LA, 0, 0, a);
        repeat (5) @(posedge clk);
        #1 resp_ready_t[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 resp_ready_t[0] = 1'b1;
        drain(0);

        // Aliasing: tag and offset bits ignored, other index untouched
        send(0, 1'b1, 32'h40, LB, 0, 1, a);   drain(0);
        send(0, 1'b0, 32'h1040, LB, 0, 1, a); drain(0);
        send(0, 1'b0, 32'h4C, LB, 0, 1, a);   drain(0);
        send(0, 1'b1, 32'h50, LC, 0, 1, a);   drain(0);
        send(0, 1'b0, 32'h40, LB, 0, 1, a);   drain(0);

        // Reset during the burst, after beat 1 was taken
        send(0, 1'b0, 32'h40, LB, 0, 1, a);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid_o[0]), 64'(0));
        chk("midrst_resp_last", 64'(resp_last_o[0]), 64'(0));
        chk("midrst_req_ready", 64'(req_ready_o[0]), 64'(0));
        q4.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(0, 1'b0, 32'h40, LB, 0, 1, a); drain(0);

        // LATENCY=1: fill three lines, then three held back-to-back reads
        send(1, 1'b1, 32'h00, LA, 0, 1, a); drain(1);
        send(1, 1'b1, 32'h10, LB, 0, 1, a); drain(1);
        send(1, 1'b1, 32'h20, LC, 0, 1, a); drain(1);
        send(1, 1'b0, 32'h00, LA, 1, 1, a0);
        send(1, 1'b0, 32'h10, LB, 1, 1, a1);
        send(1, 1'b0, 32'h20, LC, 0, 1, a2);
        drain(1);
        // accept + 1 latency + 4 beats + 1 bubble
        chk("b2b_gap_01", 64'(a1 - a0), 64'(6));
        chk("b2b_gap_12", 64'(a2 - a1), 64'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
